// File: rtl/clk_enable_ctrl_pkg.sv
// Shared definitions for the run/halt/single-step clock-enable controller:
// command opcodes (also used by the control register block) and FSM states.
package clk_enable_ctrl_pkg;

    // cmd_op encodings
    localparam logic [1:0] OP_HALT    = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_STEP    = 2'b10;
    localparam logic [1:0] OP_CLR_CNT = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

endpackage

// File: rtl/clk_step_counter.sv
// Loadable down-counter holding the number of enabled cycles left in a STEP.
// Priority: clear > load > dec. 'last' flags the final enabled cycle (count==1).
module clk_step_counter #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              dec,
    input  logic              clear,
    output logic              last
);

    logic [STEP_W-1:0] count_reg;

    // Count register: clear on reset/abort, load on STEP accept, decrement per enabled step cycle
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - STEP_W'(1);
        end
    end

    assign last = (count_reg == STEP_W'(1));

endmodule

// File: rtl/clk_enable_ctrl.sv
// Run/halt/single-step controller producing the registered clock-enable for
// the core-domain clock-gating buffer. Runs on the ungated source clock.
// Optional feature macro: CLK_ENABLE_CTRL_CYCLE_CNT_EN adds the enabled-cycle
// counter output cycle_count (CLR_CNT clears it; otherwise CLR_CNT is ignored).
module clk_enable_ctrl
    import clk_enable_ctrl_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              ext_halt,
    output logic              enable,
    output logic              halted,
    output logic              step_done
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_count
`endif
);

    state_t state_reg;
    logic   cmd_accept;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_clear;
    logic   step_last;

    // Commands are refused during a step and whenever a halt is being requested
    assign cmd_ready  = !ext_halt && (state_reg != ST_STEPPING);
    assign cmd_accept = cmd_valid && cmd_ready;

    assign cnt_load  = cmd_accept && (cmd_op == OP_STEP) && (cmd_arg != '0);
    assign cnt_dec   = (state_reg == ST_STEPPING) && enable;
    assign cnt_clear = ext_halt;

    clk_step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk      (clk_in),
        .srst     (reset),
        .load     (cnt_load),
        .load_val (cmd_arg),
        .dec      (cnt_dec),
        .clear    (cnt_clear),
        .last     (step_last)
    );

    // Control FSM; enable/halted/step_done are registered alongside the state
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg <= ST_HALTED;
            enable    <= 1'b0;
            halted    <= 1'b1;
            step_done <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (ext_halt) begin
                // External halt wins over everything and aborts a step silently
                state_reg <= ST_HALTED;
                enable    <= 1'b0;
                halted    <= 1'b1;
            end else begin
                case (state_reg)
                    ST_HALTED, ST_RUNNING: begin
                        if (cmd_accept) begin
                            case (cmd_op)
                                OP_HALT: begin
                                    state_reg <= ST_HALTED;
                                    enable    <= 1'b0;
                                    halted    <= 1'b1;
                                end
                                OP_RUN: begin
                                    state_reg <= ST_RUNNING;
                                    enable    <= 1'b1;
                                    halted    <= 1'b0;
                                end
                                OP_STEP: begin
                                    if (cmd_arg != '0) begin
                                        state_reg <= ST_STEPPING;
                                        enable    <= 1'b1;
                                        halted    <= 1'b0;
                                    end else begin
                                        // Zero-length step completes immediately
                                        step_done <= 1'b1;
                                    end
                                end
                                OP_CLR_CNT: begin
                                    // Only touches the cycle counter
                                end
                            endcase
                        end
                    end
                    ST_STEPPING: begin
                        if (step_last) begin
                            state_reg <= ST_HALTED;
                            enable    <= 1'b0;
                            halted    <= 1'b1;
                            step_done <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_HALTED;
                        enable    <= 1'b0;
                        halted    <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_count_reg;

    // Enabled-cycle counter; a clear in the same cycle as an increment yields 0
    always_ff @(posedge clk_in) begin
        if (reset || (cmd_accept && (cmd_op == OP_CLR_CNT))) begin
            cycle_count_reg <= '0;
        end else if (enable) begin
            cycle_count_reg <= cycle_count_reg + CNT_W'(1);
        end
    end

    assign cycle_count = cycle_count_reg;
`else
    // CNT_W only sizes the optional counter, which is absent in this build
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_clk_enable_ctrl.sv
// Self-checking bench for clk_enable_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a behavioural model.
// Build with CLK_ENABLE_CTRL_CYCLE_CNT_EN defined to also check cycle_count.
module tb_clk_enable_ctrl;

    localparam int STEP_W = 16;
    localparam int CNT_W  = 32;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              ext_halt;
    logic              enable;
    logic              halted;
    logic              step_done;
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0]  cycle_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    clk_enable_ctrl #(
        .STEP_W (STEP_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .ext_halt  (ext_halt),
        .enable    (enable),
        .halted    (halted),
        .step_done (step_done)
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input int arg, input logic h);
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = STEP_W'(arg);
        ext_halt  = h;
    endtask

    // One cycle: drive at the falling edge, sample shortly after
    task automatic cyc(input logic v, input logic [1:0] op, input int arg, input logic h);
        @(negedge clk_in);
        drive(v, op, arg, h);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        drive(1'b0, 2'd0, 0, 1'b0);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [1:0] op;
        int         arg;
        logic       h;
        logic       en;
        logic       hl;
        logic       sd;
        logic       rdy;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(logic v, logic [1:0] op, int arg, logic h,
                                logic en, logic hl, logic sd, logic rdy);
        vec_t r;
        r.v = v; r.op = op; r.arg = arg; r.h = h;
        r.en = en; r.hl = hl; r.sd = sd; r.rdy = rdy;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    // running: free-run requested; steps_left: enabled step cycles still owed
    bit          m_running;
    int          m_steps_left;
    bit          m_en;
    bit          m_done;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_running    = 0;
        m_steps_left = 0;
        m_en         = 0;
        m_done       = 0;
        m_cnt        = '0;
    endtask

    task automatic model_edge(input bit rst, input bit v, input logic [1:0] op,
                              input int arg, input bit h);
        bit done_n;
        bit clr;
        bit acc;
        done_n = 0;
        clr    = 0;
        if (rst) begin
            model_reset();
        end else begin
            acc = v && !h && (m_steps_left == 0);
            if (h) begin
                m_running    = 0;
                m_steps_left = 0;
            end else if (m_steps_left > 0) begin
                m_steps_left--;
                if (m_steps_left == 0) begin
                    done_n    = 1;
                    m_running = 0;
                end
            end else if (acc) begin
                case (op)
                    2'd0: m_running = 0;
                    2'd1: m_running = 1;
                    2'd2: begin
                        if (arg > 0) begin
                            m_steps_left = arg;
                            m_running    = 0;
                        end else begin
                            done_n = 1;
                        end
                    end
                    default: clr = 1;
                endcase
            end
            if (clr) m_cnt = '0;
            else if (m_en) m_cnt = m_cnt + 1;
            m_en   = m_running || (m_steps_left > 0);
            m_done = done_n;
        end
    endtask

    // Global time limit
    initial begin
        #3000000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        int en_cnt;
        int n_cyc;
        bit seen_done;
        bit r, v, h;
        logic [1:0] op;
        int arg;

        reset = 1'b1;
        drive(1'b0, 2'd0, 0, 1'b0);
        repeat (3) @(negedge clk_in);
        #1;
        chk("reset.enable", enable, 0);
        chk("reset.halted", halted, 1);
        chk("reset.step_done", step_done, 0);
        chk("reset.cmd_ready", cmd_ready, 1);
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
        chk("reset.cycle_count", cycle_count, 0);
`endif
        @(negedge clk_in);
        reset = 1'b0;

        // Idle 10 cycles after reset
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 2'd0, 0, 1'b0);
            chk("idle.enable", enable, 0);
            chk("idle.halted", halted, 1);
            chk("idle.cmd_ready", cmd_ready, 1);
            chk("idle.step_done", step_done, 0);
        end
        $display("idle: 10 cycles after reset observed");

        // Rows: inputs for the cycle, outputs observed in that same cycle
        vecs[0]  = mk(0, 2'd0, 0, 0,  0, 1, 0, 1);
        vecs[1]  = mk(1, 2'd2, 3, 0,  0, 1, 0, 1);  // STEP 3 from HALTED
        vecs[2]  = mk(0, 2'd0, 0, 0,  1, 0, 0, 0);
        vecs[3]  = mk(1, 2'd1, 0, 0,  1, 0, 0, 0);  // refused while stepping
        vecs[4]  = mk(0, 2'd0, 0, 0,  1, 0, 0, 0);
        vecs[5]  = mk(0, 2'd0, 0, 0,  0, 1, 1, 1);  // step_done
        vecs[6]  = mk(0, 2'd0, 0, 0,  0, 1, 0, 1);
        vecs[7]  = mk(1, 2'd2, 0, 0,  0, 1, 0, 1);  // STEP 0
        vecs[8]  = mk(0, 2'd0, 0, 0,  0, 1, 1, 1);
        vecs[9]  = mk(1, 2'd1, 0, 0,  0, 1, 0, 1);  // RUN
        vecs[10] = mk(0, 2'd0, 0, 0,  1, 0, 0, 1);
        vecs[11] = mk(1, 2'd2, 2, 0,  1, 0, 0, 1);  // STEP 2 from RUNNING
        vecs[12] = mk(0, 2'd0, 0, 0,  1, 0, 0, 0);
        vecs[13] = mk(0, 2'd0, 0, 0,  1, 0, 0, 0);
        vecs[14] = mk(1, 2'd1, 0, 0,  0, 1, 1, 1);  // halted after step, RUN
        vecs[15] = mk(0, 2'd0, 0, 0,  1, 0, 0, 1);
        vecs[16] = mk(0, 2'd0, 0, 1,  1, 0, 0, 0);  // ext_halt
        vecs[17] = mk(1, 2'd1, 0, 1,  0, 1, 0, 0);  // RUN refused under halt
        vecs[18] = mk(0, 2'd0, 0, 0,  0, 1, 0, 1);
        vecs[19] = mk(1, 2'd0, 0, 0,  0, 1, 0, 1);  // HALT while halted
        vecs[20] = mk(0, 2'd0, 0, 0,  0, 1, 0, 1);
        vecs[21] = mk(1, 2'd1, 0, 0,  0, 1, 0, 1);  // RUN
        vecs[22] = mk(1, 2'd2, 4, 0,  1, 0, 0, 1);  // STEP 4 while RUNNING
        vecs[23] = mk(0, 2'd0, 0, 0,  1, 0, 0, 0);  // 1st step cycle
        vecs[24] = mk(0, 2'd0, 0, 1,  1, 0, 0, 0);  // 2nd step cycle, ext_halt
        vecs[25] = mk(0, 2'd0, 0, 1,  0, 1, 0, 0);
        vecs[26] = mk(0, 2'd0, 0, 0,  0, 1, 0, 1);  // no step_done
        vecs[27] = mk(0, 2'd0, 0, 0,  0, 1, 0, 1);

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].v, vecs[i].op, vecs[i].arg, vecs[i].h);
            chk($sformatf("vec%0d.enable", i), enable, vecs[i].en);
            chk($sformatf("vec%0d.halted", i), halted, vecs[i].hl);
            chk($sformatf("vec%0d.step_done", i), step_done, vecs[i].sd);
            chk($sformatf("vec%0d.cmd_ready", i), cmd_ready, vecs[i].rdy);
            $display("vec %0d: valid=%0b op=%0d arg=%0d halt=%0b -> enable=%0b halted=%0b step_done=%0b ready=%0b",
                     i, vecs[i].v, vecs[i].op, vecs[i].arg, vecs[i].h, enable, halted, step_done, cmd_ready);
        end

        // RUN at cycle 0, HALT at cycle 15: exactly 15 enabled cycles
        do_reset();
        en_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 0) cyc(1'b1, 2'd1, 0, 1'b0);
            else if (i == 15) cyc(1'b1, 2'd0, 0, 1'b0);
            else cyc(1'b0, 2'd0, 0, 1'b0);
            if (enable) en_cnt++;
        end
        chk("runhalt.enabled_cycles", en_cnt, 15);
        chk("runhalt.halted", halted, 1);
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
        chk("runhalt.cycle_count", cycle_count, 15);
        // Clear while enabled: clear beats the same-cycle increment
        cyc(1'b1, 2'd1, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b1, 2'd3, 0, 1'b0);
        chk("clr.enable_during_clear", enable, 1);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk("clr.cycle_count_zero", cycle_count, 0);
        cyc(1'b1, 2'd0, 0, 1'b0);
        chk("clr.cycle_count_one", cycle_count, 1);
        cyc(1'b0, 2'd0, 0, 1'b0);
`endif
        $display("runhalt: enabled cycles=%0d", en_cnt);

        // Reset in the middle of a STEP 5
        do_reset();
        cyc(1'b1, 2'd2, 5, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        cyc(1'b0, 2'd0, 0, 1'b0);
        chk("midreset.enable_before", enable, 1);
        @(negedge clk_in);
        reset = 1'b1;
        drive(1'b0, 2'd0, 0, 1'b0);
        @(negedge clk_in);
        #1;
        chk("midreset.enable", enable, 0);
        chk("midreset.halted", halted, 1);
        chk("midreset.step_done", step_done, 0);
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
        chk("midreset.cycle_count", cycle_count, 0);
`endif
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'd0, 0, 1'b0);
            if (step_done || enable) seen_done = 1;
        end
        chk("midreset.quiet_after", seen_done, 0);
        $display("midreset: step abandoned");

        // Maximum step length
        do_reset();
        cyc(1'b1, 2'd2, 65535, 1'b0);
        en_cnt    = 0;
        seen_done = 0;
        n_cyc     = 0;
        while (!seen_done && n_cyc < 66000) begin
            cyc(1'b0, 2'd0, 0, 1'b0);
            n_cyc++;
            if (enable) en_cnt++;
            if (step_done) begin
                seen_done = 1;
                chk("maxstep.enable_at_done", enable, 0);
                chk("maxstep.halted_at_done", halted, 1);
            end
        end
        chk("maxstep.done_seen", seen_done, 1);
        chk("maxstep.enabled_cycles", en_cnt, 65535);
        $display("maxstep: enabled cycles=%0d", en_cnt);

        // Randomized stimulus against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_in);
            r   = ($urandom_range(99) < 2);
            h   = ($urandom_range(99) < 8);
            v   = ($urandom_range(99) < 55);
            op  = 2'($urandom_range(3));
            arg = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(6));
            reset = r;
            drive(v, op, arg, h);
            #1;
            chk("rand.enable", enable, m_en);
            chk("rand.halted", halted, !m_en);
            chk("rand.step_done", step_done, m_done);
            chk("rand.cmd_ready", cmd_ready, (!h && m_steps_left == 0));
`ifdef CLK_ENABLE_CTRL_CYCLE_CNT_EN
            chk("rand.cycle_count", cycle_count, m_cnt);
`endif
            if (!r && v && !h && m_steps_left == 0)
                $display("rand txn %0d: op=%0d arg=%0d enable=%0b", i, op, arg, enable);
            @(posedge clk_in);
            model_edge(r, v, op, arg, h);
        end
        @(negedge clk_in);
        reset = 1'b0;
        drive(1'b0, 2'd0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
